// File: rtl/orbit_update_scheduler.sv
// Round-robin scheduler that serialises per-planet orbit-angle updates through one shared trig LUT.
// Each grant advances the planet's angle by one step and publishes the sampled sine/cosine.
module orbit_update_scheduler #(
   parameter int ANGLE_W     = 8,
   parameter int DATA_W      = 10,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic               clk1485,
   input  logic               rst_n,
   input  logic               tick_mercur,
   input  logic               tick_venus,
   input  logic               tick_earth,
   input  logic               pause,
   input  logic               clr_err,
   output logic               lut_req,
   output logic [ANGLE_W-1:0] lut_angle,
   input  logic               lut_ack,
   input  logic [DATA_W-1:0]  lut_sin,
   input  logic [DATA_W-1:0]  lut_cos,
   output logic               upd_valid,
   output logic [1:0]         upd_planet,
   output logic [DATA_W-1:0]  upd_sin,
   output logic [DATA_W-1:0]  upd_cos,
   output logic [2:0]         overrun,
   output logic               lut_timeout
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_OUT} state_t;

   state_t                    state_q, state_d;
   logic [2:0]                pending_q, pending_d;
   logic [2:0][ANGLE_W-1:0]   angle_q, angle_d;
   logic [1:0]                rr_q, rr_d;
   logic [1:0]                grant_q, grant_d;
   logic [ANGLE_W-1:0]        lut_angle_q, lut_angle_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic [1:0]                planet_q, planet_d;
   logic [DATA_W-1:0]         sin_q, sin_d;
   logic [DATA_W-1:0]         cos_q, cos_d;
   logic [2:0]                overrun_q, overrun_d;
   logic                      timeout_q, timeout_d;

   logic [2:0]                tick_vec;
   logic [2:0]                grant_clr;
   logic [2:0]                ovr_set;
   logic                      commit;
   logic                      timeout_set;
   logic [1:0]                pick;
   logic                      pick_vld;
   logic [1:0]                cand1, cand2;
   logic [ANGLE_W-1:0]        pick_angle;

   function automatic logic [1:0] next3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   assign tick_vec = {tick_earth, tick_venus, tick_mercur};

   // Priority walks rr_q, rr_q+1, rr_q+2; later assignments are higher priority.
   always_comb begin
      cand1    = next3(rr_q);
      cand2    = next3(cand1);
      pick     = rr_q;
      pick_vld = 1'b0;
      if (pending_q[cand2]) begin
         pick     = cand2;
         pick_vld = 1'b1;
      end
      if (pending_q[cand1]) begin
         pick     = cand1;
         pick_vld = 1'b1;
      end
      if (pending_q[rr_q]) begin
         pick     = rr_q;
         pick_vld = 1'b1;
      end
   end

   always_comb begin
      case (pick)
         2'd1:    pick_angle = angle_q[1];
         2'd2:    pick_angle = angle_q[2];
         default: pick_angle = angle_q[0];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      grant_d     = grant_q;
      lut_angle_d = lut_angle_q;
      timer_d     = timer_q;
      planet_d    = planet_q;
      sin_d       = sin_q;
      cos_d       = cos_q;
      grant_clr   = 3'b000;
      commit      = 1'b0;
      timeout_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!pause && pick_vld) begin
               grant_clr   = 3'b001 << pick;
               grant_d     = pick;
               rr_d        = next3(pick);
               lut_angle_d = pick_angle + 1'b1;
               timer_d     = '0;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (lut_ack) begin
               sin_d    = lut_sin;
               cos_d    = lut_cos;
               planet_d = grant_q;
               commit   = 1'b1;
               state_d  = ST_OUT;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               timeout_set = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A new tick always wins over the grant clearing the same pending bit.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_planet
         assign pending_d[gi] = tick_vec[gi] | (pending_q[gi] & ~grant_clr[gi]);
         assign ovr_set[gi]   = tick_vec[gi] & pending_q[gi] & ~grant_clr[gi];
         assign overrun_d[gi] = ovr_set[gi] | (overrun_q[gi] & ~clr_err);
         assign angle_d[gi]   = (commit && (grant_q == 2'(gi))) ? lut_angle_q : angle_q[gi];
      end
   endgenerate

   assign timeout_d = timeout_set | (timeout_q & ~clr_err);

   always_ff @(posedge clk1485 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         angle_q     <= '0;
         rr_q        <= 2'd0;
         grant_q     <= 2'd0;
         lut_angle_q <= '0;
         timer_q     <= '0;
         planet_q    <= 2'd0;
         sin_q       <= '0;
         cos_q       <= '0;
         overrun_q   <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         angle_q     <= angle_d;
         rr_q        <= rr_d;
         grant_q     <= grant_d;
         lut_angle_q <= lut_angle_d;
         timer_q     <= timer_d;
         planet_q    <= planet_d;
         sin_q       <= sin_d;
         cos_q       <= cos_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
      end
   end

   assign lut_req     = (state_q == ST_REQ);
   assign upd_valid   = (state_q == ST_OUT);
   assign lut_angle   = lut_angle_q;
   assign upd_planet  = planet_q;
   assign upd_sin     = sin_q;
   assign upd_cos     = cos_q;
   assign overrun     = overrun_q;
   assign lut_timeout = timeout_q;

endmodule

// File: tb/tb_orbit_update_scheduler.sv
// Directed bench for orbit_update_scheduler: service latency, round-robin order, angle wrap,
// overrun/timeout flags and asynchronous reset.
module tb_orbit_update_scheduler;

   logic       clk1485 = 1'b0;
   logic       rst_n = 1'b1;
   logic       tick_mercur, tick_venus, tick_earth;
   logic       pause, clr_err;
   logic       lut_req;
   logic [7:0] lut_angle;
   logic       lut_ack;
   logic [9:0] lut_sin, lut_cos;
   logic       upd_valid;
   logic [1:0] upd_planet;
   logic [9:0] upd_sin, upd_cos;
   logic [2:0] overrun;
   logic       lut_timeout;

   int errors = 0;
   int checks = 0;

   int         vcyc[$];
   logic [1:0] vpl[$];
   logic [9:0] vsin[$];
   logic [7:0] rang[$];
   int         req_cycles;

   orbit_update_scheduler #(.ANGLE_W(8), .DATA_W(10), .ACK_TIMEOUT(16)) dut (
      .clk1485     (clk1485),
      .rst_n       (rst_n),
      .tick_mercur (tick_mercur),
      .tick_venus  (tick_venus),
      .tick_earth  (tick_earth),
      .pause       (pause),
      .clr_err     (clr_err),
      .lut_req     (lut_req),
      .lut_angle   (lut_angle),
      .lut_ack     (lut_ack),
      .lut_sin     (lut_sin),
      .lut_cos     (lut_cos),
      .upd_valid   (upd_valid),
      .upd_planet  (upd_planet),
      .upd_sin     (upd_sin),
      .upd_cos     (upd_cos),
      .overrun     (overrun),
      .lut_timeout (lut_timeout)
   );

   always #5 clk1485 = ~clk1485;

   task automatic step();
      @(posedge clk1485);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycle 0 carries the tick vector; records upd_valid cycles and each new LUT request angle.
   task automatic run_window(input logic [2:0] tv, input int n);
      logic prev_req;
      prev_req = 1'b0;
      req_cycles = 0;
      vcyc.delete();
      vpl.delete();
      vsin.delete();
      rang.delete();
      {tick_earth, tick_venus, tick_mercur} = tv;
      for (int i = 0; i < n; i++) begin
         if (upd_valid) begin
            vcyc.push_back(i);
            vpl.push_back(upd_planet);
            vsin.push_back(upd_sin);
            $display("txn cyc=%0d planet=%0d sin=%h cos=%h", i, upd_planet, upd_sin, upd_cos);
         end
         if (lut_req) begin
            req_cycles++;
            if (!prev_req) rang.push_back(lut_angle);
         end
         prev_req = lut_req;
         step();
         {tick_earth, tick_venus, tick_mercur} = 3'b000;
      end
   endtask

   initial begin
      {tick_earth, tick_venus, tick_mercur} = 3'b000;
      pause = 0; clr_err = 0; lut_ack = 0; lut_sin = '0; lut_cos = '0;

      // Reset values, before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req", lut_req, 0);
      chk("rst_valid", upd_valid, 0);
      chk("rst_angle", lut_angle, 0);
      chk("rst_planet", upd_planet, 0);
      chk("rst_sin", upd_sin, 0);
      chk("rst_cos", upd_cos, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", lut_timeout, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Single Venus tick, immediate ack: upd_valid in the 4th cycle counting the tick cycle
      lut_ack = 1; lut_sin = 10'h155; lut_cos = 10'h0AA;
      run_window(3'b010, 5);
      chk("a_nvalid", vcyc.size(), 1);
      chk("a_lat", vcyc[0], 3);
      chk("a_planet", vpl[0], 1);
      chk("a_sin", vsin[0], 10'h155);
      chk("a_angle", rang[0], 1);
      chk("a_cos_hold", upd_cos, 10'h0AA);
      chk("a_planet_hold", upd_planet, 1);
      chk("a_valid_low", upd_valid, 0);

      // Venus again: its angle was committed to 1, so the request is for 2
      lut_sin = 10'h2F0;
      run_window(3'b010, 5);
      chk("a2_angle", rang[0], 2);
      chk("a2_sin", vsin[0], 10'h2F0);

      // Asynchronous reset in the middle of an Earth request
      lut_ack = 0; lut_sin = 10'h3FF;
      tick_earth = 1;
      step();
      tick_earth = 0;
      step();
      chk("r_req_pre", lut_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_req", lut_req, 0);
      chk("r_angle", lut_angle, 0);
      chk("r_planet", upd_planet, 0);
      chk("r_sin", upd_sin, 0);
      chk("r_valid", upd_valid, 0);
      step(); step();
      rst_n = 1'b1;
      run_window(3'b000, 8);
      chk("r_quiet_valid", vcyc.size(), 0);
      chk("r_quiet_req", req_cycles, 0);

      // All three ticks together: Mercury, Venus, Earth, 3 cycles apart; angles all back to 0
      lut_ack = 1; lut_sin = 10'h101;
      run_window(3'b111, 11);
      chk("b_nvalid", vcyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b_lat%0d", i), vcyc[i], 3 + 3 * i);
         chk($sformatf("b_pl%0d", i), vpl[i], i);
         chk($sformatf("b_ang%0d", i), rang[i], 1);
      end
      run_window(3'b111, 11);
      chk("b2_nvalid", vcyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2_pl%0d", i), vpl[i], i);
         chk($sformatf("b2_ang%0d", i), rang[i], 2);
      end

      // Ack withheld on Earth (angle 2): 16 request cycles, sticky timeout, no update
      lut_ack = 0;
      run_window(3'b100, 25);
      chk("t_nvalid", vcyc.size(), 0);
      chk("t_reqcyc", req_cycles, 16);
      chk("t_ang", rang[0], 3);
      chk("t_flag", lut_timeout, 1);
      chk("t_req_low", lut_req, 0);
      lut_ack = 1;
      run_window(3'b100, 5);
      chk("t_retry_ang", rang[0], 3);
      chk("t_retry_nvalid", vcyc.size(), 1);
      chk("t_sticky", lut_timeout, 1);
      clr_err = 1;
      step();
      clr_err = 0;
      chk("t_clr", lut_timeout, 0);

      // Two Earth ticks under pause: overrun, set beats clear, then a single service
      pause = 1;
      tick_earth = 1;
      step();
      tick_earth = 0;
      step();
      tick_earth = 1;
      step();
      tick_earth = 0;
      chk("o_noreq", lut_req, 0);
      chk("o_flag", overrun, 3'b100);
      tick_earth = 1; clr_err = 1;
      step();
      tick_earth = 0; clr_err = 0;
      chk("o_setwins", overrun, 3'b100);
      pause = 0;
      run_window(3'b000, 10);
      chk("o_nvalid", vcyc.size(), 1);
      chk("o_pl", vpl[0], 2);
      chk("o_ang", rang[0], 4);
      clr_err = 1;
      step();
      clr_err = 0;
      chk("o_clr", overrun, 0);

      // Mercury angle walk from 2 to 254, then the wrap at 255
      for (int i = 0; i < 252; i++) run_window(3'b001, 5);
      run_window(3'b001, 5);
      chk("w_255", rang[0], 255);
      run_window(3'b001, 5);
      chk("w_wrap", rang[0], 0);
      chk("w_pl", vpl[0], 0);
      run_window(3'b001, 5);
      chk("w_commit", rang[0], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
